// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
//
// Round-robin arbiter between CORES per-core cache request ports and a single
// memory request/response port. One byte-wide read or write is granted at a
// time, issued to memory, and its completion (plus read data) is returned to
// the granted core. Exactly one transaction is outstanding at any time.
//
// Parameters:
//   CORES   number of requesting cores (>= 2, any value, not only powers of 2)
//   ADDR_W  byte address width
//   CW      core index width, $clog2(CORES)
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-low reset
//   core_req_valid   per-core request pending
//   core_req_we      per-core write enable (1 = write, 0 = read)
//   core_req_addr    per-core byte address
//   core_req_wdata   per-core write byte
//   core_req_ready   one-hot accept pulse, request captured on this edge
//   core_resp_valid  one-hot one-cycle completion pulse
//   core_resp_data   read data shared by all cores, valid with core_resp_valid
//   mem_req_valid    request to memory
//   mem_req_ready    memory accepts request
//   mem_req_we       captured write enable
//   mem_req_addr     captured address
//   mem_req_wdata    captured write byte
//   mem_resp_valid   memory completion (reads and writes)
//   mem_resp_data    memory read data
//   busy             arbiter not idle
//   grant_id         index of the current or last granted core
// ---------------------------------------------------------------------------
module core_mem_arbiter #(
    parameter int  CORES  = 3,
    parameter int  ADDR_W = 32,
    localparam int CW     = $clog2(CORES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CORES-1:0]              core_req_valid,
    input  logic [CORES-1:0]              core_req_we,
    input  logic [CORES-1:0][ADDR_W-1:0]  core_req_addr,
    input  logic [CORES-1:0][7:0]         core_req_wdata,
    output logic [CORES-1:0]              core_req_ready,
    output logic [CORES-1:0]              core_resp_valid,
    output logic [7:0]                    core_resp_data,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_we,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [7:0]                    mem_req_wdata,
    input  logic                          mem_resp_valid,
    input  logic [7:0]                    mem_resp_data,
    output logic                          busy,
    output logic [CW-1:0]                 grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    rr_ptr;
    logic [CW-1:0]    sel;
    logic             any_valid;
    logic [CORES-1:0] sel_onehot;
    logic             accept;
    logic             complete;

    // Round-robin selection: scan rr_ptr, rr_ptr+1, ... with an explicit
    // modulo-CORES wrap so non-power-of-two core counts never select a
    // nonexistent core.
    always_comb begin : sel_proc
        int idx;
        idx       = 0;
        any_valid = 1'b0;
        sel       = '0;
        for (int i = 0; i < CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= CORES) begin
                idx = idx - CORES;
            end
            if (!any_valid && core_req_valid[idx]) begin
                any_valid = 1'b1;
                sel       = CW'(idx);
            end
        end
    end

    assign sel_onehot = {{(CORES-1){1'b0}}, 1'b1} << sel;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the combinational accept pulse. Ready is gated by
    // rst so no core believes its request was taken during reset.
    always_comb begin
        next_state     = state;
        core_req_ready = '0;
        accept         = 1'b0;
        complete       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst && any_valid) begin
                    accept         = 1'b1;
                    core_req_ready = sel_onehot;
                    next_state     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    complete   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: request fields are captured only on an accept edge so they
    // stay stable however the requesters behave during ISSUE/WAIT. The
    // completion pulse is registered, landing one cycle after mem_resp_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr          <= '0;
            grant_id        <= '0;
            mem_req_we      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_wdata   <= '0;
            core_resp_valid <= '0;
            core_resp_data  <= '0;
        end else begin
            core_resp_valid <= '0;
            if (accept) begin
                grant_id      <= sel;
                mem_req_we    <= core_req_we[sel];
                mem_req_addr  <= core_req_addr[sel];
                mem_req_wdata <= core_req_wdata[sel];
                rr_ptr        <= (sel == CW'(CORES - 1)) ? '0 : sel + 1'b1;
            end
            if (complete) begin
                core_resp_valid <= {{(CORES-1){1'b0}}, 1'b1} << grant_id;
                core_resp_data  <= mem_resp_data;
            end
        end
    end

    assign mem_req_valid = (state == ST_ISSUE);
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_mem_arbiter
//
// Directed self-checking bench for core_mem_arbiter with CORES=3. Inputs are
// driven 1 time unit after each rising edge; outputs are checked after a
// further settle delay, away from the clock edge.
// ---------------------------------------------------------------------------
module tb_core_mem_arbiter;

    localparam int CORES  = 3;
    localparam int ADDR_W = 32;
    localparam int CW     = $clog2(CORES);

    logic                         clk;
    logic                         rst;
    logic [CORES-1:0]             core_req_valid;
    logic [CORES-1:0]             core_req_we;
    logic [CORES-1:0][ADDR_W-1:0] core_req_addr;
    logic [CORES-1:0][7:0]        core_req_wdata;
    logic [CORES-1:0]             core_req_ready;
    logic [CORES-1:0]             core_resp_valid;
    logic [7:0]                   core_resp_data;
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic                         mem_req_we;
    logic [ADDR_W-1:0]            mem_req_addr;
    logic [7:0]                   mem_req_wdata;
    logic                         mem_resp_valid;
    logic [7:0]                   mem_resp_data;
    logic                         busy;
    logic [CW-1:0]                grant_id;

    int compared;
    int mismatched;

    core_mem_arbiter #(
        .CORES  (CORES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_req_valid  (core_req_valid),
        .core_req_we     (core_req_we),
        .core_req_addr   (core_req_addr),
        .core_req_wdata  (core_req_wdata),
        .core_req_ready  (core_req_ready),
        .core_resp_valid (core_resp_valid),
        .core_resp_data  (core_resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load distinct addresses/data for each core, all reads.
    task automatic load_fields();
        for (int i = 0; i < CORES; i++) begin
            core_req_addr[i]  = 32'h100 + 32'(i * 16);
            core_req_wdata[i] = 8'h50 + 8'(i);
        end
        core_req_we = '0;
    endtask

    // One complete read with zero memory latency: accept, handshake, respond.
    // Entered in IDLE; leaves the arbiter in IDLE in the completion cycle with
    // core_req_valid still equal to mask, so calls can chain back-to-back.
    task automatic run_txn(input logic [2:0] mask, input int exp_g,
                           input logic [7:0] rbyte, input string tag);
        logic [2:0]  exp_oh;
        logic [31:0] exp_addr;
        exp_oh   = 3'b001 << exp_g;
        exp_addr = 32'h100 + 32'(exp_g * 16);
        core_req_valid = mask;
        #1;
        compared++;
        if (core_req_ready !== exp_oh) begin
            mismatched++;
            $display("[TB] FAIL %s ready: got %b expected %b", tag, core_req_ready, exp_oh);
        end
        tick();
        mem_req_ready = 1'b1;
        #1;
        compared++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || core_req_ready !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL %s issue: got v=%b a=%h r=%b expected v=1 a=%h r=000",
                     tag, mem_req_valid, mem_req_addr, core_req_ready, exp_addr);
        end
        compared++;
        if (grant_id !== CW'(exp_g)) begin
            mismatched++;
            $display("[TB] FAIL %s grant_id: got %0d expected %0d", tag, grant_id, exp_g);
        end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = rbyte;
        #1;
        compared++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s wait: got busy=%b v=%b expected busy=1 v=0", tag, busy, mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        compared++;
        if (core_resp_valid !== exp_oh || core_resp_data !== rbyte || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s resp: got rv=%b d=%h busy=%b expected rv=%b d=%h busy=0",
                     tag, core_resp_valid, core_resp_data, busy, exp_oh, rbyte);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        core_req_valid = 3'b111;
        tick();
        tick();
        compared++;
        if (core_req_ready !== 3'b000 || core_resp_valid !== 3'b000 || busy !== 1'b0 ||
            mem_req_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got r=%b rv=%b busy=%b v=%b expected all 0",
                     core_req_ready, core_resp_valid, busy, mem_req_valid);
        end
        compared++;
        if (mem_req_we !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 8'h00 ||
            core_resp_data !== 8'h00 || grant_id !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got we=%b a=%h wd=%h d=%h g=%0d expected all 0",
                     mem_req_we, mem_req_addr, mem_req_wdata, core_resp_data, grant_id);
        end
        core_req_valid = '0;
        rst            = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        core_req_valid   = 3'b010;
        core_req_we      = 3'b000;
        core_req_addr[1] = 32'h40;
        #1;
        compared++;
        if (core_req_ready !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL single_ready: got %b expected 010", core_req_ready);
        end
        tick();
        core_req_valid = '0;
        mem_req_ready  = 1'b1;
        #1;
        compared++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40 || mem_req_we !== 1'b0 ||
            busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_issue: got v=%b a=%h we=%b busy=%b expected v=1 a=40 we=0 busy=1",
                     mem_req_valid, mem_req_addr, mem_req_we, busy);
        end
        tick();
        mem_req_ready = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 8'hA5;
        #1;
        compared++;
        if (core_resp_valid !== 3'b000 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_wait: got rv=%b busy=%b expected rv=000 busy=1",
                     core_resp_valid, busy);
        end
        tick();
        mem_resp_valid = 1'b0;
        compared++;
        if (core_resp_valid !== 3'b010 || core_resp_data !== 8'hA5 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_resp: got rv=%b d=%h busy=%b expected rv=010 d=a5 busy=0",
                     core_resp_valid, core_resp_data, busy);
        end
        tick();
        compared++;
        if (core_resp_valid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL single_pulse_len: got %b expected 000", core_resp_valid);
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        load_fields();
        run_txn(3'b111, 0, 8'h11, "rr0");
        run_txn(3'b111, 1, 8'h22, "rr1");
        run_txn(3'b111, 2, 8'h33, "rr2");
        run_txn(3'b111, 0, 8'h44, "rr3");
        run_txn(3'b111, 1, 8'h55, "rr4");
        core_req_valid = '0;
        tick();
    endtask

    task automatic test_rr_wrap();
        run_txn(3'b101, 2, 8'h66, "wrap_c2");
        run_txn(3'b101, 0, 8'h77, "wrap_c0");
        run_txn(3'b111, 1, 8'h88, "wrap_ptr1");
        core_req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        core_req_valid    = 3'b001;
        core_req_we       = 3'b001;
        core_req_addr[0]  = 32'h1000;
        core_req_wdata[0] = 8'h3C;
        #1;
        compared++;
        if (core_req_ready !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL bp_ready: got %b expected 001", core_req_ready);
        end
        tick();
        core_req_valid    = 3'b110;
        core_req_we       = 3'b110;
        core_req_addr[0]  = 32'hDEAD;
        core_req_wdata[0] = 8'hEE;
        mem_req_ready     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            compared++;
            if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 32'h1000 ||
                mem_req_wdata !== 8'h3C || core_req_ready !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d: got v=%b we=%b a=%h wd=%h r=%b expected v=1 we=1 a=1000 wd=3c r=000",
                         c, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, core_req_ready);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        compared++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b1 || core_req_ready !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL bp_handshake: got v=%b busy=%b r=%b expected v=0 busy=1 r=000",
                     mem_req_valid, busy, core_req_ready);
        end
        core_req_valid = '0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 8'h9B;
        tick();
        mem_resp_valid = 1'b0;
        compared++;
        if (core_resp_valid !== 3'b001 || core_resp_data !== 8'h9B) begin
            mismatched++;
            $display("[TB] FAIL bp_resp: got rv=%b d=%h expected rv=001 d=9b", core_resp_valid, core_resp_data);
        end
        core_req_we = '0;
        tick();
    endtask

    task automatic test_stray_resp();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 8'h12;
        tick();
        tick();
        compared++;
        if (core_resp_valid !== 3'b000 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stray_idle: got rv=%b busy=%b v=%b expected 000/0/0",
                     core_resp_valid, busy, mem_req_valid);
        end
        mem_resp_valid   = 1'b0;
        core_req_valid   = 3'b100;
        core_req_addr[2] = 32'h120;
        tick();
        core_req_valid = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        tick();
        compared++;
        if (mem_req_valid !== 1'b1 || core_resp_valid !== 3'b000 || grant_id !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL stray_issue: got v=%b rv=%b g=%0d expected v=1 rv=000 g=2",
                     mem_req_valid, core_resp_valid, grant_id);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 8'h34;
        tick();
        mem_resp_valid = 1'b0;
        compared++;
        if (core_resp_valid !== 3'b100 || core_resp_data !== 8'h34) begin
            mismatched++;
            $display("[TB] FAIL stray_done: got rv=%b d=%h expected rv=100 d=34", core_resp_valid, core_resp_data);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        load_fields();
        core_req_valid = 3'b010;
        tick();
        core_req_valid = '0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst           = 1'b0;
        tick();
        compared++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 ||
            grant_id !== '0 || core_resp_valid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL rstwait_clear: got busy=%b v=%b a=%h g=%0d rv=%b expected all 0",
                     busy, mem_req_valid, mem_req_addr, grant_id, core_resp_valid);
        end
        rst = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 8'h77;
        tick();
        mem_resp_valid = 1'b0;
        compared++;
        if (core_resp_valid !== 3'b000 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstwait_late: got rv=%b busy=%b expected 000/0", core_resp_valid, busy);
        end
        core_req_valid = 3'b111;
        #1;
        compared++;
        if (core_req_ready !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL rstwait_regrant: got %b expected 001", core_req_ready);
        end
        core_req_valid = '0;
        tick();
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rst            = 1'b0;
        core_req_valid = '0;
        core_req_we    = '0;
        core_req_addr  = '0;
        core_req_wdata = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_rr_wrap();
        test_backpressure();
        test_stray_resp();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shared-memory arbiter between the per-core cache request ports and the single memory request/response port of the multicore system. It accepts one byte-wide read or write from up to `CORES` requesters using round-robin priority and issues it to memory. It waits for the memory response and returns completion (and read data) to the granted core. Exactly one transaction is outstanding at a time.

## Interface
- `CORES`, 3, number of requesting cores (≥2; need not be a power of two)
- `ADDR_W`, 32, byte address width
- `CW` (localparam), `$clog2(CORES)`, core index width

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset: synchronous and active-low (`rst==0` at a rising edge resets)
- `core_req_valid`  in  [CORES-1:0]  per-core request pending
- `core_req_we`  in  [CORES-1:0]  1 = write, 0 = read
- `core_req_addr`  in  [CORES-1:0][ADDR_W-1:0]  byte address
- `core_req_wdata`  in  [CORES-1:0][7:0]  write byte
- `core_req_ready`  out  [CORES-1:0]  one-hot accept pulse; request captured on this edge
- `core_resp_valid`  out  [CORES-1:0]  one-hot, 1-cycle completion pulse
- `core_resp_data`  out  8  read data, shared by all cores; valid with `core_resp_valid`
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata`  out  1 / ADDR_W / 8  captured request fields
- `mem_resp_valid`  in  1  memory completion, for reads and writes
- `mem_resp_data`  in  8  read data; don't-care for writes
- `busy`  out  1  state ≠ IDLE
- `grant_id`  out  CW  index of current or last granted core

## Operation
- FSM states: IDLE → ISSUE → WAIT → IDLE.
- **IDLE**
  - If any `core_req_valid` bit is set, select grant `g`: the first set bit scanning `rr_ptr, rr_ptr+1, …`, modulo `CORES`.
  - Assert `core_req_ready[g]` combinationally in that cycle.
  - On the edge: capture we/addr/wdata of `g` and set `grant_id=g`.
  - Update `rr_ptr = (g==CORES-1) ? 0 : g+1`. The wrap is explicit, not a power-of-two mask.
  - Go to ISSUE.
  - With no valid bit set, stay in IDLE with all outputs idle.
- **ISSUE**
  - `mem_req_valid=1`; captured fields are driven and held stable.
  - On `mem_req_valid && mem_req_ready`, go to WAIT.
  - `mem_resp_valid` in this state is ignored.
- **WAIT**
  - On `mem_resp_valid`, register `core_resp_data=mem_resp_data` and pulse `core_resp_valid[grant_id]` in the next cycle.
  - Go to IDLE.
- Write completions also pulse `core_resp_valid`. `core_resp_data` is then the sampled `mem_resp_data` value, which cores ignore.
- `mem_resp_valid` in IDLE is ignored: no state change and no pulse.
- `core_req_ready` is never asserted outside IDLE. At most one bit is ever set in `core_req_ready` and at most one in `core_resp_valid`.
- Requesters hold `valid` and fields until they see `ready`. Dropping `valid` before the grant is legal; that core is then simply not selected.

## Timing
- Reset (`rst==0` at an edge):
  - state=IDLE, `rr_ptr=0`, `grant_id=0`
  - `mem_req_valid`, `mem_req_we`, `mem_req_addr`, `mem_req_wdata` = 0
  - `core_resp_valid=0`, `core_resp_data=0`, `busy=0`
  - `core_req_ready=0` while `rst==0`
- Reset mid-transaction (ISSUE or WAIT) aborts it. No `core_resp_valid` is produced for it, and a late `mem_resp_valid` afterwards is ignored in IDLE.
- Accept at cycle T → `mem_req_valid` from T+1.
- With `mem_req_ready=1` at T+1 → WAIT at T+2.
- `mem_resp_valid` at cycle R ≥ T+2 → `core_resp_valid` at R+1.
- Minimum accept-to-completion is 3 cycles.
- The arbiter is back in IDLE in cycle R+1. It may grant a new request (`core_req_ready`) in the same cycle as `core_resp_valid`, giving 3-cycle back-to-back throughput.
- `busy` is high T+1 through R inclusive.
- `mem_req_*` fields change only on acceptance edges. They are unaffected by requester input changes during ISSUE/WAIT.

## Test plan
- Single read, core 1, addr 0x40: memory returns 0xA5 two cycles after handshake → `core_req_ready=3'b010` at T, `mem_req_addr=0x40` at T+1, `core_resp_valid=3'b010` with data 0xA5, `busy` low afterwards.
- All three cores request continuously after reset → grants in order 0,1,2,0,1; each `core_resp_valid` one-hot, matching the granted core.
- Round-robin wrap: `rr_ptr` at 2 after granting core 1; only cores 0 and 2 request → core 2 granted, then core 0; `rr_ptr` returns to 1.
- Backpressure: `mem_req_ready` low for 5 cycles on a write (addr 0x1000, data 0x3C) → `mem_req_*` stable for all 5 cycles, no `core_req_ready` pulses, single handshake.
- Stray `mem_resp_valid` in IDLE and during ISSUE → no `core_resp_valid`, state unchanged.
- Reset asserted in WAIT, `mem_resp_valid` arrives one cycle after reset deasserts → all outputs 0, no completion pulse, next request granted from core 0.
